// File: rtl/dac_sweep_sequencer.sv
// Steps the DAC LU-table points-per-period through a start..end sweep, restarting the source
// at each point, discarding settling samples, then opening an N-period acquisition window.
//   state   | meaning
//   IDLE    | waiting for start, outputs parked
//   LOAD    | latch config, first point
//   RST_SRC | hold source reset with new ptos
//   SETTLE  | discard settling samples
//   RUN     | acquisition window open
//   NEXT    | step to next point or finish
//   DONE    | completion pulse
module dac_sweep_sequencer #(
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned SETTLE_SAMPLES = 16,
    parameter logic [15:0] PTOS_IDLE      = 16'd100
) (
    input  logic        CLK_65,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] ptos_inicio,
    input  logic [15:0] ptos_fin,
    input  logic [15:0] ptos_paso,
    input  logic [15:0] ciclos_x_punto,
    input  logic        dac_data_valid,
    output logic        dac_enable,
    output logic        dac_reset_n,
    output logic [15:0] dac_ptos,
    output logic        dac_seleccion,
    output logic        acq_window,
    output logic [15:0] punto_idx,
    output logic        point_done,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RST_SRC, S_SETTLE, S_RUN, S_NEXT, S_DONE
    } state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, target, target_n;
    logic [15:0] cur, cur_n, fin, fin_n, paso, paso_n, ciclos, ciclos_n;
    logic        dir_up, dir_up_n;
    logic [16:0] step_sum;
    logic        step_stop;

    logic        nxt_enable, nxt_reset_n, nxt_seleccion, nxt_window;
    logic        nxt_point_done, nxt_busy, nxt_done, nxt_error;
    logic [15:0] nxt_ptos, nxt_idx;

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        target_n       = target;
        cur_n          = cur;
        fin_n          = fin;
        paso_n         = paso;
        ciclos_n       = ciclos;
        dir_up_n       = dir_up;
        nxt_enable     = dac_enable;
        nxt_reset_n    = dac_reset_n;
        nxt_ptos       = dac_ptos;
        nxt_seleccion  = dac_seleccion;
        nxt_window     = acq_window;
        nxt_idx        = punto_idx;
        nxt_busy       = busy;
        nxt_point_done = 1'b0;
        nxt_done       = 1'b0;
        nxt_error      = 1'b0;

        // 17-bit step so the carry/borrow bit flags leaving the 16-bit range
        step_sum  = dir_up ? ({1'b0, cur} + {1'b0, paso}) : ({1'b0, cur} - {1'b0, paso});
        step_stop = (paso == 16'd0) || step_sum[16] ||
                    (dir_up ? (step_sum[15:0] > fin) : (step_sum[15:0] < fin));

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (ptos_inicio == 16'd0 || ptos_fin == 16'd0 || ciclos_x_punto == 16'd0) begin
                        nxt_error = 1'b1;
                    end else begin
                        state_n  = S_LOAD;
                        nxt_busy = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cur_n         = ptos_inicio;
                fin_n         = ptos_fin;
                paso_n        = ptos_paso;
                ciclos_n      = ciclos_x_punto;
                dir_up_n      = (ptos_inicio <= ptos_fin);
                target_n      = 32'(ptos_inicio) * 32'(ciclos_x_punto);
                cnt_n         = 32'(RST_CYCLES - 1);
                nxt_idx       = 16'd0;
                nxt_ptos      = ptos_inicio;
                nxt_seleccion = 1'b1;
                state_n       = S_RST_SRC;
            end
            S_RST_SRC: begin
                if (cnt == 32'd0) begin
                    cnt_n       = 32'(SETTLE_SAMPLES - 1);
                    nxt_enable  = 1'b1;
                    nxt_reset_n = 1'b1;
                    state_n     = S_SETTLE;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            S_SETTLE: begin
                if (dac_data_valid) begin
                    if (cnt == 32'd0) begin
                        cnt_n      = target - 32'd1;
                        nxt_window = 1'b1;
                        state_n    = S_RUN;
                    end else begin
                        cnt_n = cnt - 32'd1;
                    end
                end
            end
            S_RUN: begin
                if (dac_data_valid) begin
                    if (cnt == 32'd0) begin
                        nxt_window     = 1'b0;
                        nxt_point_done = 1'b1;
                        state_n        = S_NEXT;
                    end else begin
                        cnt_n = cnt - 32'd1;
                    end
                end
            end
            S_NEXT: begin
                if (step_stop) begin
                    nxt_done      = 1'b1;
                    nxt_busy      = 1'b0;
                    nxt_enable    = 1'b0;
                    nxt_reset_n   = 1'b0;
                    nxt_seleccion = 1'b0;
                    nxt_ptos      = PTOS_IDLE;
                    state_n       = S_DONE;
                end else begin
                    cur_n       = step_sum[15:0];
                    target_n    = 32'(step_sum[15:0]) * 32'(ciclos);
                    cnt_n       = 32'(RST_CYCLES - 1);
                    nxt_idx     = punto_idx + 16'd1;
                    nxt_ptos    = step_sum[15:0];
                    nxt_enable  = 1'b0;
                    nxt_reset_n = 1'b0;
                    state_n     = S_RST_SRC;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // abort overrides whatever transition was computed above
        if (abort && state != S_IDLE) begin
            state_n        = S_IDLE;
            nxt_enable     = 1'b0;
            nxt_reset_n    = 1'b0;
            nxt_ptos       = PTOS_IDLE;
            nxt_seleccion  = 1'b0;
            nxt_window     = 1'b0;
            nxt_idx        = 16'd0;
            nxt_point_done = 1'b0;
            nxt_busy       = 1'b0;
            nxt_done       = 1'b0;
            nxt_error      = 1'b0;
        end
    end

    always_ff @(posedge CLK_65) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 32'd0;
            target        <= 32'd0;
            cur           <= 16'd0;
            fin           <= 16'd0;
            paso          <= 16'd0;
            ciclos        <= 16'd0;
            dir_up        <= 1'b1;
            dac_enable    <= 1'b0;
            dac_reset_n   <= 1'b0;
            dac_ptos      <= PTOS_IDLE;
            dac_seleccion <= 1'b0;
            acq_window    <= 1'b0;
            punto_idx     <= 16'd0;
            point_done    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            target        <= target_n;
            cur           <= cur_n;
            fin           <= fin_n;
            paso          <= paso_n;
            ciclos        <= ciclos_n;
            dir_up        <= dir_up_n;
            dac_enable    <= nxt_enable;
            dac_reset_n   <= nxt_reset_n;
            dac_ptos      <= nxt_ptos;
            dac_seleccion <= nxt_seleccion;
            acq_window    <= nxt_window;
            punto_idx     <= nxt_idx;
            point_done    <= nxt_point_done;
            busy          <= nxt_busy;
            done          <= nxt_done;
            error         <= nxt_error;
        end
    end

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Bench for dac_sweep_sequencer: builds the expected per-edge output trace of each sweep from
// the sweep rules and the valid-strobe pattern, then checks the DUT against it every cycle.
module tb_dac_sweep_sequencer;

    localparam int RST_CYCLES = 2;
    localparam int SETTLE     = 16;
    localparam int VMAX       = 30000;

    logic        CLK_65, reset, start, abort, dac_data_valid;
    logic [15:0] ptos_inicio, ptos_fin, ptos_paso, ciclos_x_punto;
    logic        dac_enable, dac_reset_n, dac_seleccion, acq_window, point_done, busy, done, error;
    logic [15:0] dac_ptos, punto_idx;

    dac_sweep_sequencer dut (
        .CLK_65(CLK_65), .reset(reset), .start(start), .abort(abort),
        .ptos_inicio(ptos_inicio), .ptos_fin(ptos_fin), .ptos_paso(ptos_paso),
        .ciclos_x_punto(ciclos_x_punto), .dac_data_valid(dac_data_valid),
        .dac_enable(dac_enable), .dac_reset_n(dac_reset_n), .dac_ptos(dac_ptos),
        .dac_seleccion(dac_seleccion), .acq_window(acq_window), .punto_idx(punto_idx),
        .point_done(point_done), .busy(busy), .done(done), .error(error)
    );

    initial CLK_65 = 1'b0;
    always #5 CLK_65 = ~CLK_65;

    typedef struct packed {
        logic        en, rn;
        logic [15:0] ptos;
        logic        sel, win;
        logic [15:0] idx;
        logic        idx_chk, pd, busy, dn, err;
    } exp_t;

    exp_t exp_q[$];
    bit   vpat[VMAX];
    int   win_first[64], win_len[64], settle_first[64];
    int   npts, done_edge;
    int   total = 0, passed = 0;
    bit   chk_en = 0;

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.ptos = 16'd100;
        return e;
    endfunction

    task automatic cmp(input exp_t e, input string name);
        bit ok;
        ok = (dac_enable === e.en) && (dac_reset_n === e.rn) && (dac_ptos === e.ptos) &&
             (dac_seleccion === e.sel) && (acq_window === e.win) && (point_done === e.pd) &&
             (busy === e.busy) && (done === e.dn) && (error === e.err) &&
             (!e.idx_chk || punto_idx === e.idx);
        total++;
        if (ok) passed++;
        else $display("FAIL %s t=%0t got en=%b rn=%b ptos=%0d sel=%b win=%b idx=%0d pd=%b busy=%b done=%b err=%b | want en=%b rn=%b ptos=%0d sel=%b win=%b idx=%0d(chk %b) pd=%b busy=%b done=%b err=%b",
                      name, $time, dac_enable, dac_reset_n, dac_ptos, dac_seleccion, acq_window,
                      punto_idx, point_done, busy, done, error, e.en, e.rn, e.ptos, e.sel, e.win,
                      e.idx, e.idx_chk, e.pd, e.busy, e.dn, e.err);
    endtask

    task automatic pin(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s got %0d want %0d", name, got, want);
    endtask

    always @(posedge CLK_65) begin
        #1;
        if (chk_en) begin
            if (exp_q.size() > 0) cmp(exp_q.pop_front(), "cycle");
            else cmp(idle_e(), "cycle_idle");
        end
    end

    // Expected trace, one entry per clock edge starting with the edge that samples start.
    task automatic build(input int ini, input int fin, input int paso, input int cyc);
        exp_t e, rst_e, set_e, win_e, pd_e;
        int   n, p, idx, cnt, tgt, nxt;
        bit   up, more;
        exp_q.delete();
        npts = 0;
        done_edge = -1;
        if (ini == 0 || fin == 0 || cyc == 0) begin
            e = idle_e();
            e.err = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(idle_e());
            return;
        end
        e = idle_e();
        e.busy = 1'b1;
        exp_q.push_back(e);
        n = 1; p = ini; idx = 0; up = (ini <= fin); more = 1;
        while (more) begin
            tgt = p * cyc;
            rst_e = idle_e();
            rst_e.busy = 1'b1; rst_e.sel = 1'b1; rst_e.ptos = 16'(p);
            rst_e.idx = 16'(idx); rst_e.idx_chk = 1'b1;
            set_e = rst_e; set_e.en = 1'b1; set_e.rn = 1'b1;
            win_e = set_e; win_e.win = 1'b1;
            pd_e  = set_e; pd_e.pd = 1'b1;
            for (int k = 0; k < RST_CYCLES; k++) begin exp_q.push_back(rst_e); n++; end
            settle_first[idx] = n;
            exp_q.push_back(set_e); n++;
            cnt = 0;
            while (cnt < SETTLE && n < VMAX) begin
                if (vpat[n]) cnt++;
                exp_q.push_back(cnt == SETTLE ? win_e : set_e); n++;
            end
            win_first[idx] = n - 1;
            cnt = 0;
            while (cnt < tgt && n < VMAX) begin
                if (vpat[n]) cnt++;
                exp_q.push_back(cnt == tgt ? pd_e : win_e); n++;
            end
            win_len[idx] = (n - 1) - win_first[idx];
            nxt = up ? p + paso : p - paso;
            if (paso == 0 || (up && (nxt > fin || nxt > 65535)) || (!up && (nxt < fin || nxt < 0)) ||
                n >= VMAX - 4 || idx >= 62)
                more = 0;
            else begin p = nxt; idx++; end
        end
        npts = idx + 1;
        done_edge = n;
        e = idle_e();
        e.dn = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(idle_e());
    endtask

    // Must be entered right after a negedge; drives edge 0 inputs immediately.
    // cut_kind: 0 none, 1 abort mid-RUN point 1, 2 reset mid-SETTLE point 0, 3 random abort
    task automatic run(input int ini, input int fin, input int paso, input int cyc,
                       input int vmode, input int dens, input int cut_kind, input bit noise);
        int   cut, len, end_busy;
        exp_t e;
        for (int i = 0; i < VMAX; i++)
            vpat[i] = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(i % 2) : ($urandom_range(0, 99) < dens);
        build(ini, fin, paso, cyc);
        cut = -1;
        if (done_edge > 0) begin
            if (cut_kind == 1 && npts > 1) cut = win_first[1] + 5;
            if (cut_kind == 2) cut = settle_first[0] + 3;
            if (cut_kind == 3) cut = $urandom_range(1, done_edge);
        end
        if (cut >= 0) begin
            while (exp_q.size() > cut) void'(exp_q.pop_back());
            e = idle_e();
            e.idx_chk = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(idle_e());
        end
        end_busy = (cut >= 0) ? cut : done_edge;
        len = exp_q.size();
        for (int n = 0; n < len; n++) begin
            if (n > 0) @(negedge CLK_65);
            dac_data_valid = vpat[n];
            abort = (cut_kind != 2 && n == cut);
            reset = (cut_kind == 2 && n == cut);
            start = (n == 0);
            if (n <= 1) begin
                ptos_inicio = 16'(ini); ptos_fin = 16'(fin);
                ptos_paso = 16'(paso); ciclos_x_punto = 16'(cyc);
            end else if (noise) begin
                ptos_inicio = 16'($urandom); ptos_fin = 16'($urandom);
                ptos_paso = 16'($urandom); ciclos_x_punto = 16'($urandom);
                if (n < end_busy && $urandom_range(0, 49) == 0) start = 1'b1;
            end
        end
        @(negedge CLK_65);
        start = 0; abort = 0; reset = 0; dac_data_valid = 0;
    endtask

    initial begin
        exp_t r;
        int ini, fin, paso, cyc;
        reset = 1; start = 0; abort = 0; dac_data_valid = 0;
        ptos_inicio = 0; ptos_fin = 0; ptos_paso = 0; ciclos_x_punto = 0;
        repeat (3) @(negedge CLK_65);
        r = idle_e();
        r.idx_chk = 1'b1;
        cmp(r, "reset_state");
        chk_en = 1;
        reset = 0;
        @(negedge CLK_65);

        run(100, 300, 100, 2, 0, 100, 0, 1);
        pin("t1_points", npts, 3);
        pin("t1_win0", win_len[0], 200);
        pin("t1_win1", win_len[1], 400);
        pin("t1_win2", win_len[2], 600);

        run(300, 100, 100, 1, 0, 100, 0, 0);
        pin("t2_points", npts, 3);
        pin("t2_win0", win_len[0], 300);
        pin("t2_win2", win_len[2], 100);

        run(100, 250, 100, 1, 0, 100, 0, 0);
        pin("t3_points", npts, 2);
        run(100, 300, 0, 1, 0, 100, 0, 0);
        pin("t3_paso0_points", npts, 1);

        run(10, 10, 0, 3, 1, 0, 0, 0);
        pin("t4_win_alt", win_len[0], 60);

        run(100, 300, 100, 0, 0, 100, 0, 0);
        run(0, 300, 100, 1, 0, 100, 0, 0);
        run(5, 1, 3, 2, 2, 60, 0, 1);
        run(100, 300, 100, 1, 0, 100, 1, 0);
        run(100, 300, 100, 1, 2, 70, 2, 0);

        for (int t = 0; t < 12; t++) begin
            ini  = $urandom_range(1, 40);
            fin  = $urandom_range(1, 60);
            paso = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 25);
            cyc  = $urandom_range(1, 4);
            run(ini, fin, paso, cyc, 2, $urandom_range(30, 100), ($urandom_range(0, 2) == 0) ? 3 : 0, 1);
        end

        repeat (4) @(negedge CLK_65);
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
